// File: rtl/ecall_service_unit_if.sv
// CPU-side connection of the ecall service unit: request, operands, stall and x10 write-back.
interface ecall_service_unit_if;
    logic        ecall;
    logic [31:0] a7_val;
    logic [31:0] a0_val;
    logic        stall;
    logic        wb_en;
    logic [4:0]  wb_sel;
    logic [31:0] wb_data;

    // Core / decoder side
    modport master (
        output ecall, a7_val, a0_val,
        input  stall, wb_en, wb_sel, wb_data
    );

    // Service unit side
    modport slave (
        input  ecall, a7_val, a0_val,
        output stall, wb_en, wb_sel, wb_data
    );
endinterface

// File: rtl/ecall_service_unit.sv
// Services ECALL requests: print int/char to a display register, read switches into x10,
// and halt. Stalls the single-cycle core until the service finishes.
module ecall_service_unit #(
    parameter int unsigned SW_WIDTH  = 16,
    parameter int unsigned DISP_HOLD = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    ecall_service_unit_if.slave cpu,
    input  logic [SW_WIDTH-1:0] switches,
    input  logic                confirm,
    output logic [31:0]         disp_value,
    output logic [1:0]          disp_mode,
    output logic                halted
);

    localparam int unsigned CntW = $clog2(DISP_HOLD) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DISP_HOLD - 1);

    localparam logic [31:0] SvcPrintInt  = 32'd1;
    localparam logic [31:0] SvcReadInt   = 32'd5;
    localparam logic [31:0] SvcExit      = 32'd10;
    localparam logic [31:0] SvcPrintChar = 32'd11;

    localparam logic [1:0] ModeBlank = 2'd0;
    localparam logic [1:0] ModeInt   = 2'd1;
    localparam logic [1:0] ModeChar  = 2'd2;

    typedef enum logic [1:0] {StIdle, StPrint, StRead, StHalt} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     disp_value_q, disp_value_d;
    logic [1:0]      disp_mode_q, disp_mode_d;
    logic            halted_q, halted_d;
    logic            known_code;

    assign known_code = (cpu.a7_val == SvcPrintInt) || (cpu.a7_val == SvcPrintChar) ||
                        (cpu.a7_val == SvcReadInt)  || (cpu.a7_val == SvcExit);

    // State register, hold counter and display/halt registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            disp_value_q <= '0;
            disp_mode_q  <= ModeBlank;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            disp_value_q <= disp_value_d;
            disp_mode_q  <= disp_mode_d;
            halted_q     <= halted_d;
        end
    end

    // Next-state logic; operands are only sampled on the IDLE -> service edge
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        disp_value_d = disp_value_q;
        disp_mode_d  = disp_mode_q;
        halted_d     = halted_q;
        case (state_q)
            StIdle: begin
                if (cpu.ecall) begin
                    case (cpu.a7_val)
                        SvcPrintInt: begin
                            state_d      = StPrint;
                            cnt_d        = '0;
                            disp_value_d = cpu.a0_val;
                            disp_mode_d  = ModeInt;
                        end
                        SvcPrintChar: begin
                            state_d      = StPrint;
                            cnt_d        = '0;
                            disp_value_d = {24'b0, cpu.a0_val[7:0]};
                            disp_mode_d  = ModeChar;
                        end
                        SvcReadInt: state_d = StRead;
                        SvcExit: begin
                            state_d  = StHalt;
                            halted_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            StPrint: begin
                if (cnt_q == CntLast) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRead: begin
                if (confirm) begin
                    state_d = StIdle;
                end
            end
            StHalt: ;
            default: state_d = StIdle;
        endcase
    end

    // Outputs: stall and the one-cycle x10 write on read completion
    always_comb begin
        cpu.stall   = 1'b0;
        cpu.wb_en   = 1'b0;
        cpu.wb_data = '0;
        case (state_q)
            StIdle:  cpu.stall = cpu.ecall && known_code;
            StPrint: cpu.stall = (cnt_q != CntLast);
            StRead: begin
                if (confirm) begin
                    cpu.wb_en   = 1'b1;
                    cpu.wb_data = 32'(switches);
                end else begin
                    cpu.stall = 1'b1;
                end
            end
            StHalt:  cpu.stall = 1'b1;
            default: cpu.stall = 1'b0;
        endcase
    end

    assign cpu.wb_sel = 5'd10;
    assign disp_value = disp_value_q;
    assign disp_mode  = disp_mode_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_ecall_service_unit.sv
// Self-checking bench for ecall_service_unit: directed scenarios plus random service sequences
// compared against a transaction-level model of each service.
module tb_ecall_service_unit;

    localparam int unsigned SW_WIDTH  = 16;
    localparam int unsigned DISP_HOLD = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [SW_WIDTH-1:0] switches;
    logic                confirm;
    logic [31:0]         disp_value;
    logic [1:0]          disp_mode;
    logic                halted;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] exp_disp;
    logic [1:0]  exp_mode;

    ecall_service_unit_if bus ();

    ecall_service_unit #(
        .SW_WIDTH (SW_WIDTH),
        .DISP_HOLD(DISP_HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu       (bus),
        .switches  (switches),
        .confirm   (confirm),
        .disp_value(disp_value),
        .disp_mode (disp_mode),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Model: stall cycles a completed service costs the core
    function automatic int model_stalls(input logic [31:0] code, input int conf_at);
        if (code == 32'd1 || code == 32'd11) return DISP_HOLD;
        if (code == 32'd5) return conf_at;
        return 0;
    endfunction

    // Model: display effect of a service
    task automatic model_display(input logic [31:0] code, input logic [31:0] arg);
        if (code == 32'd1) begin
            exp_disp = arg;
            exp_mode = 2'd1;
        end else if (code == 32'd11) begin
            exp_disp = arg & 32'h0000_00FF;
            exp_mode = 2'd2;
        end
    endtask

    // Acts as the core: holds ecall until the instruction retires (stall low at an edge).
    // confirm is also pulsed in the entry cycle of a read to show it is ignored there.
    task automatic run_ecall(input logic [31:0] code, input logic [31:0] arg,
                             input logic [SW_WIDTH-1:0] sw, input int conf_at,
                             output int stalls, output int wbs, output logic [31:0] wbd);
        int cyc = 0;
        bit done = 0;
        stalls = 0;
        wbs    = 0;
        wbd    = 32'hDEAD_BEEF;
        bus.ecall  = 1'b1;
        bus.a7_val = code;
        bus.a0_val = arg;
        switches   = sw;
        while (!done && cyc < 200) begin
            confirm = (code == 32'd5) && (cyc == 0 || cyc == conf_at);
            @(negedge clk);
            if (bus.stall) stalls++;
            else done = 1;
            if (bus.wb_en) begin
                wbs++;
                wbd = bus.wb_data;
                check("wb_sel", 32'(bus.wb_sel), 32'd10);
            end else begin
                check("wb_data_idle", bus.wb_data, 32'd0);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!done) check("service_timeout", 32'd1, 32'd0);
        bus.ecall = 1'b0;
        confirm   = 1'b0;
    endtask

    task automatic do_service(input string tag, input logic [31:0] code, input logic [31:0] arg,
                              input logic [SW_WIDTH-1:0] sw, input int conf_at);
        int          stalls;
        int          wbs;
        logic [31:0] wbd;
        run_ecall(code, arg, sw, conf_at, stalls, wbs, wbd);
        model_display(code, arg);
        check({tag, "_stalls"}, 32'(stalls), 32'(model_stalls(code, conf_at)));
        check({tag, "_wb_count"}, 32'(wbs), (code == 32'd5) ? 32'd1 : 32'd0);
        if (code == 32'd5) check({tag, "_wb_data"}, wbd, 32'(sw));
        check({tag, "_disp_value"}, disp_value, exp_disp);
        check({tag, "_disp_mode"}, 32'(disp_mode), 32'(exp_mode));
        check({tag, "_halted"}, 32'(halted), 32'd0);
    endtask

    initial begin
        logic [31:0] code;
        int          pick;

        rst_n      = 1'b0;
        bus.ecall  = 1'b0;
        bus.a7_val = '0;
        bus.a0_val = '0;
        switches   = '0;
        confirm    = 1'b0;
        exp_disp   = '0;
        exp_mode   = 2'd0;

        // Reset state
        #12;
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_wb_en", 32'(bus.wb_en), 32'd0);
        check("rst_wb_data", bus.wb_data, 32'd0);
        check("rst_disp_value", disp_value, 32'd0);
        check("rst_disp_mode", 32'(disp_mode), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed services
        do_service("print_int", 32'd1, 32'h0000_1234, 16'h0, 0);
        do_service("print_char", 32'd11, 32'hFFFF_FF41, 16'h0, 0);
        do_service("read_int", 32'd5, 32'h0, 16'hBEEF, 8);

        // Unknown code: no stall in the request cycle itself
        bus.ecall  = 1'b1;
        bus.a7_val = 32'd7;
        #1 check("unknown_same_cycle_stall", 32'(bus.stall), 32'd0);
        do_service("unknown", 32'd7, 32'h5555_5555, 16'h0, 0);

        // Back-to-back print then read with no idle gap
        do_service("b2b_print", 32'd1, 32'hCAFE_0001, 16'h0, 0);
        do_service("b2b_read", 32'd5, 32'h0, 16'h1357, 2);

        // Random service mix against the model
        for (int t = 0; t < 40; t++) begin
            pick = $urandom_range(0, 3);
            case (pick)
                0: code = 32'd1;
                1: code = 32'd11;
                2: code = 32'd5;
                default: begin
                    do code = $urandom_range(0, 40);
                    while (code == 32'd1 || code == 32'd5 || code == 32'd10 || code == 32'd11);
                end
            endcase
            do_service("rand", code, $urandom, SW_WIDTH'($urandom), $urandom_range(1, 6));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        // Reset in the middle of a read: abandoned without a write to x10
        bus.ecall  = 1'b1;
        bus.a7_val = 32'd5;
        switches   = 16'hA5A5;
        @(posedge clk);
        #1 bus.ecall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("read_wait_stall", 32'(bus.stall), 32'd1);
            check("read_wait_wb_en", 32'(bus.wb_en), 32'd0);
        end
        #2 rst_n = 1'b0;
        #1;
        check("read_rst_stall", 32'(bus.stall), 32'd0);
        check("read_rst_wb_en", 32'(bus.wb_en), 32'd0);
        check("read_rst_disp_value", disp_value, 32'd0);
        exp_disp = '0;
        exp_mode = 2'd0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        do_service("post_rst_print", 32'd1, 32'd5, 16'h0, 0);

        // Exit: halted after one edge, sticky through ecall/confirm activity
        bus.ecall  = 1'b1;
        bus.a7_val = 32'd10;
        @(negedge clk);
        check("exit_entry_stall", 32'(bus.stall), 32'd1);
        check("exit_entry_halted", 32'(halted), 32'd0);
        @(posedge clk);
        #1;
        check("exit_halted", 32'(halted), 32'd1);
        check("exit_stall", 32'(bus.stall), 32'd1);
        for (int i = 0; i < 20; i++) begin
            bus.ecall  = 1'($urandom);
            confirm    = 1'($urandom);
            bus.a7_val = $urandom_range(0, 12);
            bus.a0_val = $urandom;
            @(negedge clk);
            check("halt_stall", 32'(bus.stall), 32'd1);
            check("halt_halted", 32'(halted), 32'd1);
            check("halt_wb_en", 32'(bus.wb_en), 32'd0);
            @(posedge clk);
            #1;
        end
        bus.ecall = 1'b0;
        confirm   = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("halt_rst_halted", 32'(halted), 32'd0);
        check("halt_rst_stall", 32'(bus.stall), 32'd0);
        check("halt_rst_disp_value", disp_value, 32'd0);
        check("halt_rst_disp_mode", 32'(disp_mode), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
